broadcast_queue: RTL and testbench
==================================

# broadcast_queue

Result-collection stage directly downstream of the execution functional units (FU_AND and its siblings). Each FU's single-cycle `done` pulse, result and execution tag are captured into a per-FU holding slot. Occupied slots are drained round-robin into a circular FIFO, and the FIFO head is broadcast on the common data bus one entry per accepted cycle. `fu_queued[i]` closes the FU's idle handshake.

## Interface
- `NUM_FU`, 4, number of functional units served
- `DATA_WIDTH`, 32, result width
- `TAG_WIDTH`, 7, execution tag width
- `DEPTH`, 8, FIFO entries; power of two, ≥2
- `clk`  in  1  single clock; all state on rising edge
- `rst`  in  1  reset, asynchronous and active-low: asserting (0) clears all state immediately, independent of `clk`
- `fu_done`  in  NUM_FU  per-FU completion pulse
- `fu_result`  in  NUM_FU*DATA_WIDTH  packed results; FU i at bits [i*DATA_WIDTH +: DATA_WIDTH]
- `fu_tag`  in  NUM_FU*TAG_WIDTH  packed tags, same packing
- `fu_queued`  out  NUM_FU  combinational; high in the cycle FU i's done is captured
- `cdb_valid`  out  1  FIFO head valid
- `cdb_data`  out  DATA_WIDTH  head result
- `cdb_tag`  out  TAG_WIDTH  head tag
- `cdb_ready`  in  1  consumer accepts head this cycle
- `count`  out  $clog2(DEPTH)+1  FIFO occupancy
- `full`, `empty`  out  1  FIFO status

## Operation
- Slots, one per FU (valid, data, tag):
  - `fu_queued[i] = fu_done[i] & (~slot_valid[i] | grant[i])`.
  - On `fu_queued[i]`, the slot loads the result and tag and stays valid.
  - On `grant[i]` without a capture, the slot clears.
- Dropped done: `fu_done[i]` with `fu_queued[i]=0` is not captured. The FU never sees queued, stays non-idle, and is not re-dispatched. This is intentional back-pressure to dispatch.
- Arbiter:
  - `req = slot_valid`. At most one grant per cycle, and only if `push_ok = ~full | pop`.
  - Round-robin: search starts at `rr_ptr`. After a grant to i, `rr_ptr` becomes (i+1) mod NUM_FU. With no grant, `rr_ptr` holds.
- FIFO: circular buffer with `wr_ptr` and `rd_ptr`, each $clog2(DEPTH) bits, plus a separate `count`.
  - push = any grant; pop = `cdb_valid & cdb_ready`.
  - Pointers wrap modulo DEPTH.
  - Push+pop in the same cycle leaves count unchanged, including when full (push allowed because pop frees a slot) and when empty (impossible: empty implies no pop).
- `cdb_*` driven directly from the `rd_ptr` entry; `cdb_valid = ~empty`. Head data is stable while `cdb_valid & ~cdb_ready`.
- Order: FIFO order is grant order. Tags from one FU are never reordered.

## Timing
- Reset (`rst`=0, async): all slot_valid=0, count=0, wr_ptr=rd_ptr=rr_ptr=0.
  - Outputs: `cdb_valid`=0, `empty`=1, `full`=0, `fu_queued`=0 (all `fu_done`=0 during reset).
  - `cdb_data`/`cdb_tag` = 0.
  - Reset mid-operation discards every slot and FIFO entry.
  - Release is synchronised by the integrator; the first capture is allowed on the first edge after release.
- Latency with idle queue: done at cycle t → slot valid at t+1 → granted and pushed at t+1 → `cdb_valid` at t+2.
- Throughput: one push and one pop per cycle.
- Simultaneous done from all FUs: all captured in the same cycle; drained over NUM_FU cycles.
- Full with `cdb_ready`=0: no grants; slots hold; further done on occupied slots is dropped per the rule above.

## Structure
- Shared header: `DATA_WIDTH` and `TAG_WIDTH` defaults (common with the FUs), and the packed-port slicing convention.
- Sub-module `rr_arbiter` (NUM_FU req, enable, one-hot grant, internal `rr_ptr`).
- FIFO storage stays inline.

## Test plan
- Single op: `fu_done[1]`, result 0xDEADBEEF, tag 5 at t → `fu_queued[1]`=1 at t; `cdb_valid`, 0xDEADBEEF, tag 5 at t+2; pops with `cdb_ready`=1; `empty`=1 after.
- Simultaneous: all 4 done (tags 10..13), `rr_ptr`=2 → broadcast order 12, 13, 10, 11 on consecutive cycles; all four `fu_queued` high in the same cycle.
- Full back-pressure: `cdb_ready`=0, 8 pushes → `full`=1, `count`=8; then FU0 done with slot occupied → `fu_queued[0]`=0. Raise `cdb_ready` → 8 entries drain in order; the slot then drains.
- Wrap-around: 20 pushes/pops interleaved with `cdb_ready` toggling → tag order preserved; `count` never exceeds 8 or underflows.
- Full with simultaneous push+pop: `count`=8, `cdb_ready`=1, slot pending → grant occurs; `count` stays 8.
- Async reset mid-stream: drive `rst`=0 between clock edges with 3 entries queued → `cdb_valid`=0 and `count`=0 before the next edge; no stale tag after release.

Source files
------------

// File: rtl/broadcast_queue_pkg.sv
// ============================================================================
// Module      : broadcast_queue_pkg
// Description : Shared defaults for the result-collection stage. DATA_WIDTH
//               and TAG_WIDTH defaults match the execution FUs. Packed FU
//               ports put FU i at bits [i*W +: W].
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package broadcast_queue_pkg;

  localparam int DEF_NUM_FU     = 4;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_TAG_WIDTH  = 7;
  localparam int DEF_DEPTH      = 8;

  // Round-robin successor of an FU index
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1) % n;
  endfunction

endpackage

`default_nettype wire

// File: rtl/broadcast_queue_rr_arbiter.sv
// ============================================================================
// Module      : rr_arbiter
// Description : Round-robin arbiter. One-hot grant to the first requester at
//               or after rr_ptr; the pointer moves past the winner and holds
//               when nothing is granted.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter
  import broadcast_queue_pkg::*;
#(
  parameter int NUM_FU = DEF_NUM_FU
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_FU-1:0] req_i,
  input  logic              en_i,
  output logic [NUM_FU-1:0] grant_o
);

  localparam int PW = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

  logic [PW-1:0] rr_ptr_q;
  logic [PW-1:0] rr_ptr_d;
  logic [PW-1:0] idx;
  logic          found;

  // Priority search starting at rr_ptr; first active request wins
  always_comb begin
    grant_o  = '0;
    rr_ptr_d = rr_ptr_q;
    found    = 1'b0;
    idx      = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      idx = PW'((int'(rr_ptr_q) + k) % NUM_FU);
      if (en_i && !found && req_i[idx]) begin
        grant_o[idx] = 1'b1;
        found        = 1'b1;
        rr_ptr_d     = PW'(rr_next(int'(idx), NUM_FU));
      end
    end
  end

  // Pointer register, cleared by asynchronous reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/broadcast_queue.sv
// ============================================================================
// Module      : broadcast_queue
// Description : Captures FU completions into per-FU slots, drains occupied
//               slots round-robin into a circular FIFO and broadcasts the
//               FIFO head on the common data bus.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module broadcast_queue
  import broadcast_queue_pkg::*;
#(
  parameter int NUM_FU     = DEF_NUM_FU,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int TAG_WIDTH  = DEF_TAG_WIDTH,
  parameter int DEPTH      = DEF_DEPTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_FU-1:0]            fu_done,
  input  logic [NUM_FU*DATA_WIDTH-1:0] fu_result,
  input  logic [NUM_FU*TAG_WIDTH-1:0]  fu_tag,
  output logic [NUM_FU-1:0]            fu_queued,
  output logic                         cdb_valid,
  output logic [DATA_WIDTH-1:0]        cdb_data,
  output logic [TAG_WIDTH-1:0]         cdb_tag,
  input  logic                         cdb_ready,
  output logic [$clog2(DEPTH):0]       count,
  output logic                         full,
  output logic                         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // Per-FU holding slots
  logic [NUM_FU-1:0]     slot_valid_q;
  logic [NUM_FU-1:0]     slot_valid_d;
  logic [DATA_WIDTH-1:0] slot_data_q [NUM_FU];
  logic [TAG_WIDTH-1:0]  slot_tag_q  [NUM_FU];

  // FIFO storage and pointers
  logic [DATA_WIDTH-1:0] mem_data_q [DEPTH];
  logic [TAG_WIDTH-1:0]  mem_tag_q  [DEPTH];
  logic [AW-1:0]         wr_ptr_q;
  logic [AW-1:0]         rd_ptr_q;
  logic [CW-1:0]         count_q;
  logic [CW-1:0]         count_d;

  logic [NUM_FU-1:0]     grant;
  logic                  push;
  logic                  pop;
  logic                  push_ok;
  logic [DATA_WIDTH-1:0] push_data;
  logic [TAG_WIDTH-1:0]  push_tag;

  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign cdb_valid = ~empty;
  assign cdb_data  = mem_data_q[rd_ptr_q];
  assign cdb_tag   = mem_tag_q[rd_ptr_q];
  assign pop       = cdb_valid & cdb_ready;
  // A pop in the same cycle frees the slot a push needs when full
  assign push_ok   = ~full | pop;
  assign push      = |grant;
  // A busy slot can still accept when it is being drained this cycle
  assign fu_queued = fu_done & (~slot_valid_q | grant);

  rr_arbiter #(
    .NUM_FU (NUM_FU)
  ) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req_i   (slot_valid_q),
    .en_i    (push_ok),
    .grant_o (grant)
  );

  // Slot occupancy: capture keeps the slot valid, grant alone clears it
  always_comb begin
    slot_valid_d = slot_valid_q;
    for (int i = 0; i < NUM_FU; i++) begin
      if (fu_queued[i]) begin
        slot_valid_d[i] = 1'b1;
      end else if (grant[i]) begin
        slot_valid_d[i] = 1'b0;
      end
    end
  end

  // Select the granted slot's contents for the FIFO write
  always_comb begin
    push_data = '0;
    push_tag  = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      if (grant[i]) begin
        push_data = slot_data_q[i];
        push_tag  = slot_tag_q[i];
      end
    end
  end

  // Occupancy next state; simultaneous push and pop cancel
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Slot registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot_valid_q <= '0;
      for (int i = 0; i < NUM_FU; i++) begin
        slot_data_q[i] <= '0;
        slot_tag_q[i]  <= '0;
      end
    end else begin
      slot_valid_q <= slot_valid_d;
      for (int i = 0; i < NUM_FU; i++) begin
        if (fu_queued[i]) begin
          slot_data_q[i] <= fu_result[i*DATA_WIDTH +: DATA_WIDTH];
          slot_tag_q[i]  <= fu_tag[i*TAG_WIDTH +: TAG_WIDTH];
        end
      end
    end
  end

  // FIFO storage, pointers and occupancy; storage cleared so the bus reads 0
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int j = 0; j < DEPTH; j++) begin
        mem_data_q[j] <= '0;
        mem_tag_q[j]  <= '0;
      end
    end else begin
      if (push) begin
        mem_data_q[wr_ptr_q] <= push_data;
        mem_tag_q[wr_ptr_q]  <= push_tag;
        wr_ptr_q             <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      count_q <= count_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_broadcast_queue.sv
// ============================================================================
// Module      : tb_broadcast_queue
// Description : Directed self-checking bench for broadcast_queue.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_broadcast_queue;

  logic         clk;
  logic         rst;
  logic [3:0]   fu_done;
  logic [127:0] fu_result;
  logic [27:0]  fu_tag;
  logic [3:0]   fu_queued;
  logic         cdb_valid;
  logic [31:0]  cdb_data;
  logic [6:0]   cdb_tag;
  logic         cdb_ready;
  logic [3:0]   count;
  logic         full;
  logic         empty;

  int errors = 0;
  int checks = 0;

  broadcast_queue #(
    .NUM_FU     (4),
    .DATA_WIDTH (32),
    .TAG_WIDTH  (7),
    .DEPTH      (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .fu_done   (fu_done),
    .fu_result (fu_result),
    .fu_tag    (fu_tag),
    .fu_queued (fu_queued),
    .cdb_valid (cdb_valid),
    .cdb_data  (cdb_data),
    .cdb_tag   (cdb_tag),
    .cdb_ready (cdb_ready),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fu(input int i, input logic [31:0] d, input logic [6:0] t);
    fu_result[i*32 +: 32] = d;
    fu_tag[i*7 +: 7]      = t;
  endtask

  function automatic logic [31:0] res_of(input logic [6:0] t);
    return 32'hC0DE_0000 | {25'd0, t};
  endfunction

  logic [6:0] expq[$];
  logic       done_prev;
  logic [6:0] tag_prev;

  initial begin
    rst       = 1'b0;
    fu_done   = '0;
    fu_result = '0;
    fu_tag    = '0;
    cdb_ready = 1'b0;

    // ---------------- reset state ----------------
    repeat (3) @(posedge clk);
    #1;
    check("rst_cdb_valid", cdb_valid, 1'b0);
    check("rst_empty", empty, 1'b1);
    check("rst_full", full, 1'b0);
    check("rst_count", count, 4'd0);
    check("rst_queued", fu_queued, 4'b0000);
    check("rst_cdb_data", cdb_data, 32'h0);
    check("rst_cdb_tag", cdb_tag, 7'h0);
    rst = 1'b1;
    tick();

    // ---------------- single op on FU1 ----------------
    cdb_ready = 1'b1;
    set_fu(1, 32'hDEADBEEF, 7'd5);
    fu_done = 4'b0010;
    #1;
    check("single_queued", fu_queued, 4'b0010);
    tick();
    fu_done = '0;
    #1;
    check("single_t1_valid", cdb_valid, 1'b0);
    tick();
    check("single_t2_valid", cdb_valid, 1'b1);
    check("single_t2_data", cdb_data, 32'hDEADBEEF);
    check("single_t2_tag", cdb_tag, 7'd5);
    check("single_t2_count", count, 4'd1);
    tick();
    check("single_empty_after", empty, 1'b1);

    // ---------------- simultaneous done, rr_ptr = 2 ----------------
    for (int i = 0; i < 4; i++) set_fu(i, res_of(7'(10 + i)), 7'(10 + i));
    fu_done = 4'b1111;
    #1;
    check("simul_queued", fu_queued, 4'b1111);
    tick();
    fu_done = '0;
    tick();
    check("simul_tag0", cdb_tag, 7'd12);
    check("simul_data0", cdb_data, res_of(7'd12));
    tick();
    check("simul_tag1", cdb_tag, 7'd13);
    check("simul_count1", count, 4'd1);
    tick();
    check("simul_tag2", cdb_tag, 7'd10);
    tick();
    check("simul_tag3", cdb_tag, 7'd11);
    check("simul_data3", cdb_data, res_of(7'd11));
    tick();
    check("simul_empty", empty, 1'b1);

    // ---------------- fill with back-pressure ----------------
    cdb_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      set_fu(0, res_of(7'(30 + i)), 7'(30 + i));
      fu_done = 4'b0001;
      #1;
      check("fill_queued", fu_queued, 4'b0001);
      tick();
    end
    set_fu(0, res_of(7'd39), 7'd39);
    fu_done = 4'b0001;
    #1;
    check("full_flag", full, 1'b1);
    check("full_count", count, 4'd8);
    check("full_dropped_queued", fu_queued, 4'b0000);
    check("full_head_tag", cdb_tag, 7'd30);
    tick();
    fu_done = '0;
    check("full_hold_count", count, 4'd8);
    check("full_hold_tag", cdb_tag, 7'd30);
    check("full_hold_data", cdb_data, res_of(7'd30));
    // Pop and pending slot push coincide while full
    cdb_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      check("drain_tag", cdb_tag, 64'(30 + k));
      check("drain_count", count, 64'(9 - k));
    end
    tick();
    check("drain_empty", empty, 1'b1);

    // ---------------- wrap-around with toggling ready ----------------
    expq.delete();
    done_prev = 1'b0;
    tag_prev  = '0;
    for (int n = 0; n < 72; n++) begin
      logic       dn;
      logic       rdy;
      logic [6:0] t;
      dn  = (n < 40) && (n % 2 == 0);
      rdy = (n % 3 != 0);
      t   = 7'(40 + n / 2);
      fu_done = '0;
      if (dn) begin
        if ((n / 2) % 2 == 1) begin
          set_fu(3, res_of(t), t);
          fu_done[3] = 1'b1;
        end else begin
          set_fu(1, res_of(t), t);
          fu_done[1] = 1'b1;
        end
      end
      cdb_ready = rdy;
      #1;
      check("wrap_count", count, 64'(expq.size()));
      check("wrap_valid", cdb_valid, (expq.size() != 0) ? 1'b1 : 1'b0);
      check("wrap_queued", fu_queued, fu_done);
      if (expq.size() != 0) begin
        check("wrap_tag", cdb_tag, expq[0]);
        check("wrap_data", cdb_data, res_of(expq[0]));
        if (rdy) void'(expq.pop_front());
      end
      if (done_prev) expq.push_back(tag_prev);
      done_prev = dn;
      tag_prev  = t;
      tick();
    end
    fu_done = '0;
    cdb_ready = 1'b1;
    tick();
    check("wrap_final_empty", empty, 1'b1);

    // ---------------- async reset mid-stream ----------------
    cdb_ready = 1'b0;
    for (int i = 0; i < 3; i++) set_fu(i, res_of(7'(70 + i)), 7'(70 + i));
    fu_done = 4'b0111;
    tick();
    fu_done = '0;
    repeat (3) tick();
    check("areset_pre_count", count, 4'd3);
    check("areset_pre_valid", cdb_valid, 1'b1);
    #3;
    rst = 1'b0;
    #1;
    check("areset_valid", cdb_valid, 1'b0);
    check("areset_count", count, 4'd0);
    check("areset_empty", empty, 1'b1);
    check("areset_tag", cdb_tag, 7'd0);
    tick();
    rst = 1'b1;
    cdb_ready = 1'b1;
    tick();
    check("post_rst_valid", cdb_valid, 1'b0);
    set_fu(2, res_of(7'd99), 7'd99);
    fu_done = 4'b0100;
    #1;
    check("post_rst_queued", fu_queued, 4'b0100);
    tick();
    fu_done = '0;
    check("post_rst_t1_valid", cdb_valid, 1'b0);
    tick();
    check("post_rst_t2_valid", cdb_valid, 1'b1);
    check("post_rst_t2_tag", cdb_tag, 7'd99);
    check("post_rst_t2_data", cdb_data, res_of(7'd99));
    tick();
    check("post_rst_empty", empty, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
